// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 memory stage.
//
// Contents:
//   ADDR_W / DATA_W / DEPTH  - MAR width, W-bus width, RAM depth (DEPTH == 2**ADDR_W)
//   state_e                  - memory-unit FSM states; the encoding is visible on
//                              the unit's debug state output
//   ctrl_word bit indices    - layout of the SAP-1 controller word. The memory unit
//                              receives ctrl_word[MAR_LOAD] on mar_load_n_i and
//                              ctrl_word[RAM_EN] on ram_en_n_i (both active-low).
package sap1_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    HOLD  = 2'd2,
    RUN   = 2'd3
  } state_e;

  // Controller word bit positions, MSB first: Cp Ep Lm' CE' Li' Ei' La' Ea' Su Eu Lb' Lo'
  localparam int INCR_PC      = 11;
  localparam int PC_OUT       = 10;
  localparam int MAR_LOAD     = 9;
  localparam int RAM_EN       = 8;
  localparam int IR_LOAD      = 7;
  localparam int IR_EN        = 6;
  localparam int A_LOAD       = 5;
  localparam int A_EN         = 4;
  localparam int ALU_SUB      = 3;
  localparam int ALU_EN       = 2;
  localparam int B_LOAD       = 1;
  localparam int OUT_REG_LOAD = 0;
  localparam int CTRL_W       = 12;

endpackage

// File: rtl/sap1_ram16x8.sv
// 16x8 RAM for the SAP-1 memory stage: one synchronous write port, one
// asynchronous (combinational) read port. Contents are not reset.
//
// Ports:
//   clk_i    - write clock (rising edge)
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - mem[raddr_i], combinational
module sap1_ram16x8
  import sap1_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sap1_mem_unit.sv
// SAP-1 memory stage: 4-bit MAR plus 16x8 RAM with a programming front-end.
//
// After reset the RAM is swept to zero (CLEAR, DEPTH cycles). The unit then
// either accepts a program byte stream (LOAD) or goes straight to RUN. After a
// load it waits in HOLD until run mode is selected. The rest of the CPU is held
// in reset (cpu_rstn_o=0) in every state except RUN.
//
// Program stream handshake: a byte is transferred on a rising edge where
// prog_valid_i and prog_ready_o are both high; prog_ready_o is high exactly
// in LOAD and does not depend on prog_valid_i. The producer may hold valid
// low for any number of cycles; nothing is written then.
//
// Optional build macro: SAP1_MEM_CHECKSUM_EN adds checksum_o, the mod-256
// sum of all bytes accepted since the last entry into LOAD.
//
// Ports:
//   clk_i         - clock, rising edge (the controller uses the falling edge)
//   rstn_i        - asynchronous active-low reset
//   mode_prog_i   - 1 = programming mode requested, 0 = run mode
//   mar_load_n_i  - controller MAR_LOAD (active-low), honoured only in RUN
//   ram_en_n_i    - controller RAM_EN (active-low), honoured only in RUN
//   bus_i         - W-bus; low ADDR_W bits feed the MAR
//   bus_o         - mem[mar]
//   bus_oe_o      - bus drive enable, RUN and RAM_EN asserted
//   prog_valid_i / prog_data_i / prog_last_i / prog_ready_o - program stream
//   prog_done_o   - program load complete (HOLD and RUN)
//   cpu_rstn_o    - active-low reset to the rest of the CPU
//   checksum_o    - (SAP1_MEM_CHECKSUM_EN only) running sum of loaded bytes
//   dbg_state_o   - current FSM state (state_e encoding)
module sap1_mem_unit
  import sap1_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              mode_prog_i,
  input  logic              mar_load_n_i,
  input  logic              ram_en_n_i,
  input  logic [DATA_W-1:0] bus_i,
  output logic [DATA_W-1:0] bus_o,
  output logic              bus_oe_o,
  input  logic              prog_valid_i,
  input  logic [DATA_W-1:0] prog_data_i,
  input  logic              prog_last_i,
  output logic              prog_ready_o,
  output logic              prog_done_o,
  output logic              cpu_rstn_o,
`ifdef SAP1_MEM_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum_o,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] mar_q, mar_d;

  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic              xfer;

  // Only the address bits of the W-bus reach the MAR.
  logic unused_bus_hi;
  assign unused_bus_hi = ^bus_i[DATA_W-1:ADDR_W];

  // ---------------------------------------------------------------------------
  // State, pointer and MAR registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      mar_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mar_q   <= mar_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and RAM write port
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mar_d     = mar_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    xfer      = 1'b0;

    case (state_q)
      CLEAR: begin
        ram_we = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_ADDR) begin
          ptr_d   = '0;
          state_d = mode_prog_i ? LOAD : RUN;
        end
      end

      LOAD: begin
        // mode_prog_i is deliberately not looked at here: a load only ends
        // on the last byte or when the memory is full.
        if (prog_valid_i) begin
          xfer      = 1'b1;
          ram_we    = 1'b1;
          ram_wdata = prog_data_i;
          ptr_d     = ptr_q + ADDR_W'(1);
          if (prog_last_i || ptr_q == LAST_ADDR) begin
            ptr_d   = '0;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (!mode_prog_i) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (!mar_load_n_i) begin
          mar_d = bus_i[ADDR_W-1:0];
        end
        // Re-programming skips CLEAR, so bytes past the new program survive.
        if (mode_prog_i) begin
          ptr_d   = '0;
          state_d = LOAD;
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  sap1_ram16x8 u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ptr_q),
    .wdata_i (ram_wdata),
    .raddr_i (mar_q),
    .rdata_o (bus_o)
  );

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from the registered state, so the asynchronous reset
  // forces them to their reset values immediately.
  // ---------------------------------------------------------------------------
  assign prog_ready_o = (state_q == LOAD);
  assign prog_done_o  = (state_q == HOLD) || (state_q == RUN);
  assign cpu_rstn_o   = (state_q == RUN);
  assign bus_oe_o     = (state_q == RUN) && !ram_en_n_i;
  assign dbg_state_o  = state_q;

`ifdef SAP1_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    checksum_d = checksum_q;
    if (state_d == LOAD && state_q != LOAD) begin
      checksum_d = '0;
    end else if (xfer) begin
      checksum_d = checksum_q + prog_data_i;
    end
  end

  assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_sap1_mem_unit.sv
// Self-checking bench for sap1_mem_unit. A behavioural model tracks the phase,
// load position, MAR and memory image; a compare process checks every output
// against it each falling edge. Directed steps pin literal values.
module tb_sap1_mem_unit;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b1;
  logic       mode_prog_i = 1'b0;
  logic       mar_load_n_i = 1'b1;
  logic       ram_en_n_i = 1'b1;
  logic [7:0] bus_i = 8'h00;
  logic [7:0] bus_o;
  logic       bus_oe_o;
  logic       prog_valid_i = 1'b0;
  logic [7:0] prog_data_i = 8'h00;
  logic       prog_last_i = 1'b0;
  logic       prog_ready_o;
  logic       prog_done_o;
  logic       cpu_rstn_o;
  logic [1:0] dbg_state_o;
`ifdef SAP1_MEM_CHECKSUM_EN
  logic [7:0] checksum_o;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------- clock
  always #5 clk_i = ~clk_i;

  sap1_mem_unit dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .mode_prog_i  (mode_prog_i),
    .mar_load_n_i (mar_load_n_i),
    .ram_en_n_i   (ram_en_n_i),
    .bus_i        (bus_i),
    .bus_o        (bus_o),
    .bus_oe_o     (bus_oe_o),
    .prog_valid_i (prog_valid_i),
    .prog_data_i  (prog_data_i),
    .prog_last_i  (prog_last_i),
    .prog_ready_o (prog_ready_o),
    .prog_done_o  (prog_done_o),
    .cpu_rstn_o   (cpu_rstn_o),
`ifdef SAP1_MEM_CHECKSUM_EN
    .checksum_o   (checksum_o),
`endif
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------------------------------------------------------- model
  // phase: 0 clearing, 1 loading, 2 loaded/waiting, 3 running
  int         m_phase = 0;
  int         m_clear_left = 16;
  int         m_pos = 0;
  logic [3:0] m_mar = 4'h0;
  logic [7:0] m_sum = 8'h00;
  logic [7:0] m_mem [16];

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_phase      <= 0;
      m_clear_left <= 16;
      m_pos        <= 0;
      m_mar        <= 4'h0;
      m_sum        <= 8'h00;
    end else begin
      case (m_phase)
        0: begin
          m_mem[16 - m_clear_left] <= 8'h00;
          m_clear_left <= m_clear_left - 1;
          if (m_clear_left == 1) begin
            m_phase <= mode_prog_i ? 1 : 3;
            m_pos   <= 0;
            m_sum   <= 8'h00;
          end
        end
        1: begin
          if (prog_valid_i) begin
            m_mem[m_pos] <= prog_data_i;
            m_sum        <= m_sum + prog_data_i;
            m_pos        <= m_pos + 1;
            if (prog_last_i || m_pos == 15) begin
              m_phase <= 2;
              m_pos   <= 0;
            end
          end
        end
        2: begin
          if (!mode_prog_i) m_phase <= 3;
        end
        default: begin
          if (!mar_load_n_i) m_mar <= bus_i[3:0];
          if (mode_prog_i) begin
            m_phase <= 1;
            m_pos   <= 0;
            m_sum   <= 8'h00;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- checker
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    chk("state", {6'b0, dbg_state_o}, 8'(m_phase));
    chk("prog_ready", {7'b0, prog_ready_o}, {7'b0, m_phase == 1});
    chk("prog_done", {7'b0, prog_done_o}, {7'b0, m_phase >= 2});
    chk("cpu_rstn", {7'b0, cpu_rstn_o}, {7'b0, m_phase == 3});
    chk("bus_oe", {7'b0, bus_oe_o}, {7'b0, (m_phase == 3) && !ram_en_n_i});
    if (m_phase == 3) chk("bus_o", bus_o, m_mem[m_mar]);
`ifdef SAP1_MEM_CHECKSUM_EN
    chk("checksum", checksum_o, m_sum);
`endif
  end

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic mode);
    ram_en_n_i   = 1'b0;
    prog_valid_i = 1'b0;
    prog_last_i  = 1'b0;
    rstn_i       = 1'b0;
    #2;
    chk("rst_ready", {7'b0, prog_ready_o}, 8'h00);
    chk("rst_done", {7'b0, prog_done_o}, 8'h00);
    chk("rst_cpu_rstn", {7'b0, cpu_rstn_o}, 8'h00);
    chk("rst_oe", {7'b0, bus_oe_o}, 8'h00);
    mode_prog_i = mode;
    step();
    rstn_i = 1'b1;
    repeat (15) step();
    chk("clear_15_state", {6'b0, dbg_state_o}, 8'h00);
    step();
    chk("clear_16_cpu_rstn", {7'b0, cpu_rstn_o}, {7'b0, !mode});
    chk("clear_16_ready", {7'b0, prog_ready_o}, {7'b0, mode});
  endtask

  task automatic mar_read(input logic [3:0] a, input logic [7:0] exp);
    mar_load_n_i = 1'b0;
    bus_i        = {4'h0, a};
    step();
    mar_load_n_i = 1'b1;
    chk("mar_read", bus_o, exp);
  endtask

  task automatic send(input logic [7:0] d, input logic v, input logic l);
    prog_valid_i = v;
    prog_data_i  = d;
    prog_last_i  = l;
    step();
    prog_valid_i = 1'b0;
    prog_last_i  = 1'b0;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      mar_load_n_i = 1'($urandom_range(0, 1));
      ram_en_n_i   = 1'($urandom_range(0, 1));
      bus_i        = 8'($urandom_range(0, 255));
      step();
    end
    mar_load_n_i = 1'b1;
  endtask

  task automatic random_load();
    int budget;
    mode_prog_i = 1'b1;
    step();
    budget = 200;
    while (m_phase != 2 && budget > 0) begin
      prog_valid_i = 1'($urandom_range(0, 1));
      prog_data_i  = 8'($urandom_range(0, 255));
      prog_last_i  = ($urandom_range(0, 9) == 0);
      step();
      budget--;
    end
    prog_valid_i = 1'b0;
    prog_last_i  = 1'b0;
    chk("random_load_done", {7'b0, prog_done_o}, 8'h01);
    mode_prog_i = 1'b0;
    step();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [7:0] prog5 [5];
    prog5 = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0};
    #1;

    // Reset straight into run mode, then read a cleared word.
    do_reset(1'b0);
    ram_en_n_i = 1'b0;
    mar_read(4'h5, 8'h00);
    chk("oe_run", {7'b0, bus_oe_o}, 8'h01);

    // Five-byte program with last on the final byte.
    mode_prog_i = 1'b1;
    step();
    for (int i = 0; i < 5; i++) send(prog5[i], 1'b1, i == 4);
    chk("p5_done", {7'b0, prog_done_o}, 8'h01);
    chk("p5_ready", {7'b0, prog_ready_o}, 8'h00);
    chk("p5_cpu_rstn", {7'b0, cpu_rstn_o}, 8'h00);
    mode_prog_i = 1'b0;
    step();
    mar_read(4'h3, 8'hE0);
    mar_read(4'h4, 8'hF0);

    // Valid toggling: the invalid byte is not written.
    mode_prog_i = 1'b1;
    step();
    send(8'hAA, 1'b1, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    send(8'hBB, 1'b1, 1'b1);
    mode_prog_i = 1'b0;
    step();
    mar_read(4'h0, 8'hAA);
    mar_read(4'h1, 8'hBB);
    mar_read(4'h2, 8'h2B);

    // Full 16-byte load without last; a 17th byte is refused.
    mode_prog_i = 1'b1;
    step();
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b1, 1'b0);
    chk("full_state_hold", {6'b0, dbg_state_o}, 8'h02);
    chk("full_ready", {7'b0, prog_ready_o}, 8'h00);
    send(8'h77, 1'b1, 1'b0);
    mode_prog_i = 1'b0;
    step();
    mar_read(4'h0, 8'h10);
    mar_read(4'hF, 8'h1F);

    // Both strobes in one cycle: old word before the edge, new word after.
    ram_en_n_i   = 1'b0;
    mar_load_n_i = 1'b0;
    bus_i        = 8'hF7;
    #2;
    chk("same_cycle_before", bus_o, 8'h1F);
    step();
    mar_load_n_i = 1'b1;
    chk("same_cycle_after", bus_o, 8'h17);

    random_run(40);

    // Reset into programming mode; checksum of 0xFF + 0x02.
    do_reset(1'b1);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b1);
`ifdef SAP1_MEM_CHECKSUM_EN
    chk("checksum_lit", checksum_o, 8'h01);
`endif
    mode_prog_i = 1'b0;
    step();

    // Reset mid-load after three bytes; CLEAR zeroes them again.
    mode_prog_i = 1'b1;
    step();
    send(8'h31, 1'b1, 1'b0);
    send(8'h32, 1'b1, 1'b0);
    send(8'h33, 1'b1, 1'b0);
    do_reset(1'b0);
    mar_read(4'h0, 8'h00);
    mar_read(4'h1, 8'h00);
    mar_read(4'h2, 8'h00);

    // Randomised loads followed by randomised bus traffic.
    for (int r = 0; r < 6; r++) begin
      random_load();
      random_run(30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
